// File: rtl/ne16_package.sv
// ne16_package: shared constants and control/flag types for the NE16 partial-result collector.
package ne16_package;
   localparam int unsigned NE16_NB_COLUMNS       = 9;
   localparam int unsigned NE16_COLUMN_PRES_SIZE = 28;
   localparam int unsigned NE16_ACC_SIZE         = 32;
   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} pres_collector_state_t;
   typedef struct packed {
      logic                       start;
      logic [15:0]                nb_iter;
      logic [NE16_NB_COLUMNS-1:0] enable_column;
   } ctrl_pres_collector_t;
   typedef struct packed {
      pres_collector_state_t state;
      logic [15:0]           iter_cnt;
      logic                  done;
      logic                  sat;
   } flags_pres_collector_t;
endpackage

// File: rtl/ne16_pres_accumulator.sv
// ne16_pres_accumulator: one signed accumulator register with clear and add.
// NE16_PRES_COLLECTOR_SAT_EN selects saturating adds (sat_o flags a clipped add); otherwise it wraps.
module ne16_pres_accumulator
   import ne16_package::*;
#(
   parameter int unsigned PRES_WIDTH = NE16_COLUMN_PRES_SIZE,
   parameter int unsigned ACC_WIDTH  = NE16_ACC_SIZE
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  clr_i,
   input  logic                  add_i,
   input  logic [PRES_WIDTH-1:0] data_i,
   output logic [ACC_WIDTH-1:0]  acc_o,
   output logic                  sat_o
);
   logic [ACC_WIDTH-1:0] r_acc, w_next;
`ifdef NE16_PRES_COLLECTOR_SAT_EN
   logic [ACC_WIDTH:0] w_sum;
   logic               w_ovf;
   assign w_sum  = {r_acc[ACC_WIDTH-1], r_acc} + {{(ACC_WIDTH+1-PRES_WIDTH){data_i[PRES_WIDTH-1]}}, data_i};
   // the extra top bit disagrees with the sign bit exactly when the add overflowed
   assign w_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
   assign w_next = w_ovf ? {w_sum[ACC_WIDTH], {(ACC_WIDTH-1){~w_sum[ACC_WIDTH]}}} : w_sum[ACC_WIDTH-1:0];
   assign sat_o  = add_i && w_ovf;
`else
   assign w_next = r_acc + {{(ACC_WIDTH-PRES_WIDTH){data_i[PRES_WIDTH-1]}}, data_i};
   assign sat_o  = 1'b0;
`endif
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_acc <= '0;
      else if (clr_i) r_acc <= '0;
      else if (add_i) r_acc <= w_next;
   assign acc_o = r_acc;
endmodule

// File: rtl/ne16_pres_collector.sv
// ne16_pres_collector: accumulates all column partial-result streams for nb_iter beats, then drains one column per beat.
// NE16_PRES_COLLECTOR_SAT_EN enables saturating accumulation with a sticky flags_o.sat.
module ne16_pres_collector
   import ne16_package::*;
#(
   parameter int unsigned NB_COLUMNS = NE16_NB_COLUMNS,
   parameter int unsigned PRES_WIDTH = NE16_COLUMN_PRES_SIZE,
   parameter int unsigned ACC_WIDTH  = NE16_ACC_SIZE
) (
   input  logic                                 clk_i,
   input  logic                                 rst_ni,
   input  logic                                 test_mode_i,
   input  logic                                 enable_i,
   input  logic                                 clear_i,
   input  logic [NB_COLUMNS-1:0]                column_pres_valid_i,
   input  logic [NB_COLUMNS-1:0][PRES_WIDTH-1:0] column_pres_data_i,
   output logic [NB_COLUMNS-1:0]                column_pres_ready_o,
   output logic                                 acc_valid_o,
   output logic [ACC_WIDTH-1:0]                 acc_data_o,
   output logic [ACC_WIDTH/8-1:0]               acc_strb_o,
   input  logic                                 acc_ready_i,
   input  ctrl_pres_collector_t                 ctrl_i,
   output flags_pres_collector_t                flags_o
);
   localparam int unsigned COL_W = NB_COLUMNS > 1 ? $clog2(NB_COLUMNS) : 1;
   pres_collector_state_t r_state, w_next_state;
   logic [15:0]           r_iter_cnt;
   logic [COL_W-1:0]      r_col_idx;
   logic                  r_done, r_sat;
   logic                  w_start, w_accept, w_hs, w_last_iter, w_last_col, w_unused;
   logic [NB_COLUMNS-1:0] w_en, w_sat;
   logic [ACC_WIDTH-1:0]  w_acc [NB_COLUMNS];
   assign w_unused    = test_mode_i;
   assign w_en        = ctrl_i.enable_column[NB_COLUMNS-1:0];
   assign w_start     = r_state == IDLE && ctrl_i.start;
   // disabled columns never hold back an accept
   assign w_accept    = r_state == ACCUM && enable_i && &(column_pres_valid_i | ~w_en);
   assign w_hs        = r_state == DRAIN && acc_ready_i;
   assign w_last_iter = r_iter_cnt == (ctrl_i.nb_iter == 16'd0 ? 16'd0 : ctrl_i.nb_iter - 16'd1);
   assign w_last_col  = r_col_idx == COL_W'(NB_COLUMNS-1);
   for (genvar c = 0; c < NB_COLUMNS; c++) begin : g_col
      ne16_pres_accumulator #(
         .PRES_WIDTH(PRES_WIDTH),
         .ACC_WIDTH (ACC_WIDTH)
      ) i_acc (
         .clk_i (clk_i),
         .rst_ni(rst_ni),
         .clr_i (clear_i || w_start),
         .add_i (w_accept && w_en[c]),
         .data_i(column_pres_data_i[c]),
         .acc_o (w_acc[c]),
         .sat_o (w_sat[c])
      );
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) r_state <= IDLE;
      else r_state <= w_next_state;
   always_comb begin
      w_next_state = clear_i ? IDLE :
                     w_start ? ACCUM :
                     (w_accept && w_last_iter) ? DRAIN :
                     (w_hs && w_last_col) ? IDLE : r_state;
   end
   always_comb begin
      column_pres_ready_o = {NB_COLUMNS{r_state == ACCUM && enable_i}};
      acc_valid_o         = r_state == DRAIN;
      acc_data_o          = r_state == DRAIN ? w_acc[r_col_idx] : '0;
      acc_strb_o          = r_state == DRAIN ? '1 : '0;
      flags_o             = '{state: r_state, iter_cnt: r_iter_cnt, done: r_done, sat: r_sat};
   end
   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         r_iter_cnt <= '0;
         r_col_idx  <= '0;
         r_done     <= 1'b0;
         r_sat      <= 1'b0;
      end else begin
         r_done <= !clear_i && w_hs && w_last_col;
         if (clear_i || w_start) begin
            r_iter_cnt <= '0;
            r_col_idx  <= '0;
            r_sat      <= 1'b0;
         end else begin
            if (w_accept) r_iter_cnt <= r_iter_cnt + 16'd1;
            if (w_accept) r_sat <= r_sat || |w_sat;
            if (w_hs) r_col_idx <= w_last_col ? '0 : r_col_idx + COL_W'(1);
         end
      end
endmodule
